// File: rtl/gps_sig_gen_pkg.sv
// Shared types, constants and PRN tap table for the synthetic GPS L1 C/A source.
package gps_sig_gen_pkg;

  localparam int unsigned CA_LEN     = 1023;
  localparam int unsigned CHIP_W     = 10;
  localparam int unsigned LFSR_W     = 10;
  localparam int unsigned SAT_W      = 6;
  localparam int unsigned DOP_W      = 16;
  localparam int unsigned CODE_ACC_W = 18;

  // Carrier LO lookup indexed by carrier phase quadrant
  localparam logic [3:0] LO_SIN = 4'b1100;
  localparam logic [3:0] LO_COS = 4'b0110;

  // Feedback taps, bit n-1 set for stage n (stage 10 is the output stage)
  localparam logic [LFSR_W-1:0] G1_FB_MASK = 10'b10_0000_0100;
  localparam logic [LFSR_W-1:0] G2_FB_MASK = 10'b11_1010_0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Two-stage G2 tap mask
  function automatic logic [LFSR_W-1:0] tap_mask(input int unsigned a, input int unsigned b);
    return (LFSR_W'(1) << (a - 1)) | (LFSR_W'(1) << (b - 1));
  endfunction

  // G2 phase-selector taps per PRN
  function automatic logic [LFSR_W-1:0] prn_g2_mask(input logic [SAT_W-1:0] sat);
    case (sat)
      6'd1:  return tap_mask(2, 6);
      6'd2:  return tap_mask(3, 7);
      6'd3:  return tap_mask(4, 8);
      6'd4:  return tap_mask(5, 9);
      6'd5:  return tap_mask(1, 9);
      6'd6:  return tap_mask(2, 10);
      6'd7:  return tap_mask(1, 8);
      6'd8:  return tap_mask(2, 9);
      6'd9:  return tap_mask(3, 10);
      6'd10: return tap_mask(2, 3);
      6'd11: return tap_mask(3, 4);
      6'd12: return tap_mask(5, 6);
      6'd13: return tap_mask(6, 7);
      6'd14: return tap_mask(7, 8);
      6'd15: return tap_mask(8, 9);
      6'd16: return tap_mask(9, 10);
      6'd17: return tap_mask(1, 4);
      6'd18: return tap_mask(2, 5);
      6'd19: return tap_mask(3, 6);
      6'd20: return tap_mask(4, 7);
      6'd21: return tap_mask(5, 8);
      6'd22: return tap_mask(6, 9);
      6'd23: return tap_mask(1, 3);
      6'd24: return tap_mask(4, 6);
      6'd25: return tap_mask(5, 7);
      6'd26: return tap_mask(6, 8);
      6'd27: return tap_mask(7, 9);
      6'd28: return tap_mask(8, 10);
      6'd29: return tap_mask(1, 6);
      6'd30: return tap_mask(2, 7);
      6'd31: return tap_mask(3, 8);
      6'd32: return tap_mask(4, 9);
      default: return tap_mask(2, 6);
    endcase
  endfunction

  // Start configuration acceptance
  function automatic logic cfg_valid(input logic [SAT_W-1:0] sat, input logic [CHIP_W-1:0] ph);
    return (sat >= 6'd1) && (sat <= 6'd32) && (ph <= CHIP_W'(CA_LEN - 1));
  endfunction

endpackage

// File: rtl/gps_sig_gen_if.sv
// Control/config and sample-output bundle between a bench/host and gps_sig_gen.
interface gps_sig_gen_if;
  import gps_sig_gen_pkg::*;

  logic              start;
  logic              stop;
  logic [SAT_W-1:0]  sat;
  logic [CHIP_W-1:0] code_phase_init;
  logic [DOP_W-1:0]  doppler_omega;
  logic              nav_data;
  logic              adc_clk;
  logic              i_sample;
  logic              q_sample;
  logic              busy;
  logic              epoch;
  logic              cfg_err;

  modport master (
    output start, stop, sat, code_phase_init, doppler_omega, nav_data,
    input  adc_clk, i_sample, q_sample, busy, epoch, cfg_err
  );

  modport slave (
    input  start, stop, sat, code_phase_init, doppler_omega, nav_data,
    output adc_clk, i_sample, q_sample, busy, epoch, cfg_err
  );
endinterface

// File: rtl/gps_sig_gen_ca_code_gen.sv
// C/A Gold code generator: G1/G2 LFSRs with per-PRN G2 tap selection.
module ca_code_gen
  import gps_sig_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             reload_i,
  input  logic [SAT_W-1:0] sat_i,
  output logic             chip_c_o
);

  logic [LFSR_W:1] g1_q, g1_d;
  logic [LFSR_W:1] g2_q, g2_d;

  // LFSR state registers, all-ones at reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g1_q <= '1;
      g2_q <= '1;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
    end
  end

  // Reload takes priority over a step
  always_comb begin
    g1_d = g1_q;
    g2_d = g2_q;
    if (reload_i) begin
      g1_d = '1;
      g2_d = '1;
    end else if (step_i) begin
      g1_d = {g1_q[LFSR_W-1:1], ^(g1_q & G1_FB_MASK)};
      g2_d = {g2_q[LFSR_W-1:1], ^(g2_q & G2_FB_MASK)};
    end
  end

  assign chip_c_o = g1_q[LFSR_W] ^ (^(g2_q & prn_g2_mask(sat_i)));

endmodule

// File: rtl/gps_sig_gen.sv
// Synthetic GPS L1 C/A baseband source: 1-bit I/Q plus adc_clk sample strobe.
// Optional navigation-bit modulation enabled by defining GPS_SIG_GEN_NAV_EN.
module gps_sig_gen
  import gps_sig_gen_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV     = 4,
  parameter int unsigned CODE_NCO_OMEGA = 67027,
  parameter int unsigned NAV_EPOCHS     = 20
) (
  input  logic         clk,
  input  logic         rst,
  gps_sig_gen_if.slave bus
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SAMPLE_DIV / 2);

  state_e                state_q, state_d;
  logic [SAT_W-1:0]      sat_q, sat_d;
  logic [CHIP_W-1:0]     phase_q, phase_d;
  logic [CHIP_W-1:0]     load_cnt_q, load_cnt_d;
  logic [CHIP_W-1:0]     chip_cnt_q, chip_cnt_d;
  logic [CODE_ACC_W-1:0] code_acc_q, code_acc_d;
  logic [DOP_W-1:0]      dop_q, dop_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  adc_q, adc_d;
  logic                  i_q, i_d;
  logic                  q_q, q_d;
  logic                  busy_q, busy_d;
  logic                  epoch_q, epoch_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  step_c, reload_c, chip_c, code_carry, nav;
  logic [1:0]            ph;

  ca_code_gen u_ca (
    .clk      (clk),
    .rst      (rst),
    .step_i   (step_c),
    .reload_i (reload_c),
    .sat_i    (sat_q),
    .chip_c_o (chip_c)
  );

  // State, NCO and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sat_q      <= '0;
      phase_q    <= '0;
      load_cnt_q <= '0;
      chip_cnt_q <= '0;
      code_acc_q <= '0;
      dop_q      <= '0;
      div_q      <= '0;
      adc_q      <= 1'b0;
      i_q        <= 1'b0;
      q_q        <= 1'b0;
      busy_q     <= 1'b0;
      epoch_q    <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sat_q      <= sat_d;
      phase_q    <= phase_d;
      load_cnt_q <= load_cnt_d;
      chip_cnt_q <= chip_cnt_d;
      code_acc_q <= code_acc_d;
      dop_q      <= dop_d;
      div_q      <= div_d;
      adc_q      <= adc_d;
      i_q        <= i_d;
      q_q        <= q_d;
      busy_q     <= busy_d;
      epoch_q    <= epoch_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // FSM next state, code/carrier NCOs and sample generation
  always_comb begin
    state_d    = state_q;
    sat_d      = sat_q;
    phase_d    = phase_q;
    load_cnt_d = load_cnt_q;
    chip_cnt_d = chip_cnt_q;
    code_acc_d = code_acc_q;
    dop_d      = dop_q;
    div_d      = div_q;
    adc_d      = 1'b0;
    i_d        = i_q;
    q_d        = q_q;
    epoch_d    = 1'b0;
    cfg_err_d  = 1'b0;
    step_c     = 1'b0;
    reload_c   = 1'b0;
    code_carry = 1'b0;
    ph         = dop_q[DOP_W-1:DOP_W-2];

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (cfg_valid(bus.sat, bus.code_phase_init)) begin
            state_d    = ST_LOAD;
            sat_d      = bus.sat;
            phase_d    = bus.code_phase_init;
            load_cnt_d = '0;
            chip_cnt_d = bus.code_phase_init;
            code_acc_d = '0;
            dop_d      = '0;
            div_d      = '0;
            reload_c   = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // Slew the LFSRs to the requested chip, one step per clock
        if (load_cnt_q == phase_q) begin
          state_d = ST_RUN;
        end else begin
          step_c     = 1'b1;
          load_cnt_d = load_cnt_q + CHIP_W'(1);
          if (load_cnt_q + CHIP_W'(1) == phase_q) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        adc_d = (div_q >= DIV_HALF);
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        if (div_q == '0) begin
          i_d   = chip_c ^ LO_COS[ph] ^ nav;
          q_d   = chip_c ^ LO_SIN[ph] ^ nav;
          dop_d = dop_q + bus.doppler_omega;
          {code_carry, code_acc_d} = {1'b0, code_acc_q} + (CODE_ACC_W + 1)'(CODE_NCO_OMEGA);
          if (code_carry) begin
            if (chip_cnt_q == CHIP_W'(CA_LEN - 1)) begin
              chip_cnt_d = '0;
              reload_c   = 1'b1;
              epoch_d    = 1'b1;
            end else begin
              chip_cnt_d = chip_cnt_q + CHIP_W'(1);
              step_c     = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.stop) begin
      state_d  = ST_IDLE;
      adc_d    = 1'b0;
      i_d      = 1'b0;
      q_d      = 1'b0;
      epoch_d  = 1'b0;
      step_c   = 1'b0;
      reload_c = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

`ifdef GPS_SIG_GEN_NAV_EN
  localparam int unsigned NAV_W = (NAV_EPOCHS > 1) ? $clog2(NAV_EPOCHS) : 1;

  logic             nav_q, nav_d;
  logic [NAV_W-1:0] nav_ep_q, nav_ep_d;

  // Nav bit registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nav_q    <= 1'b0;
      nav_ep_q <= '0;
    end else begin
      nav_q    <= nav_d;
      nav_ep_q <= nav_ep_d;
    end
  end

  // Nav bit latched on run entry, then once every NAV_EPOCHS code epochs
  always_comb begin
    nav_d    = nav_q;
    nav_ep_d = nav_ep_q;
    if (state_q == ST_LOAD && state_d == ST_RUN) begin
      nav_d    = bus.nav_data;
      nav_ep_d = '0;
    end else if (epoch_d) begin
      if (nav_ep_q == NAV_W'(NAV_EPOCHS - 1)) begin
        nav_ep_d = '0;
        nav_d    = bus.nav_data;
      end else begin
        nav_ep_d = nav_ep_q + NAV_W'(1);
      end
    end
  end

  assign nav = nav_q;
`else
  logic unused_nav;
  assign unused_nav = bus.nav_data ^ (NAV_EPOCHS == 0);
  assign nav        = 1'b0;
`endif

  assign bus.adc_clk  = adc_q;
  assign bus.i_sample = i_q;
  assign bus.q_sample = q_q;
  assign bus.busy     = busy_q;
  assign bus.epoch    = epoch_q;
  assign bus.cfg_err  = cfg_err_q;

endmodule
